per_bus_mailbox: RTL and testbench
==================================

// Module: per_bus_mailbox
// PURPOSE
//  Peripheral-bus responder: target end of the phi2-timed bus driven by the bus controller.
//  Decodes its own chip select, exposes a 4-register window and two byte FIFOs (host->local TX,
//  local->host RX). Used as the SMC / expansion-side mailbox. Level IRQ output goes to the interrupt controller.
// PARAMETERS
//  FIFO_DEPTH     16  entries per FIFO; power of two, 4..256
//  SYNC_STAGES     2  flops on phi2 / cs_n / read_write before edge detection
//  WR_SAMPLE      20  clk cycles after synced phi2 rise at which data_in is captured (6 ns clk)
// PORTS
//  clk         in   1  system clock (166.67 MHz)
//  reset       in   1  synchronous, active-high reset
//  phi2        in   1  bus clock, asynchronous to clk
//  cs_n        in   1  device select, active low
//  read_write  in   1  1 = read, 0 = write
//  address     in   6  register address; only [1:0] decoded, [5:2] alias
//  data_in     in   8  bus write data
//  data_out    out  8  bus read data
//  data_oe     out  1  drive enable for data_out (tri-state is at top level)
//  tx_data     out  8  head of TX FIFO to local logic
//  tx_valid    out  1  TX FIFO not empty
//  tx_ready    in   1  local pop; pop on tx_valid & tx_ready
//  rx_data     in   8  local write data into RX FIFO
//  rx_valid    in   1  local push; push on rx_valid & rx_ready
//  rx_ready    out  1  RX FIFO not full
//  irq_n       out  1  interrupt request, active low, level
// BEHAVIOUR
//  Reset: data_out=0, data_oe=0, irq_n=1, tx_valid=0, rx_ready=1, both FIFOs empty, IRQ_EN=0, errors=0.
//  Reset mid-bus-cycle aborts the cycle: no push/pop, data_oe=0 until the next synced phi2 rise.
//  Sync: phi2/cs_n/read_write through SYNC_STAGES flops; rise/fall from last two stages.
//  FSM IDLE -> (synced rise & !cs_n) latch address/read_write -> READ or WRITE; else stay IDLE.
//   READ: cycle after rise, data_out <= register value, data_oe=1; held until synced fall;
//         at fall data_oe=0, side effect (pop) commits, -> IDLE.
//   WRITE: counter from rise; at count==WR_SAMPLE capture data_in; at synced fall commit, -> IDLE.
//         If fall arrives before WR_SAMPLE, capture data_in on the fall cycle.
//  Register map (address[1:0]):
//   0 STATUS  R: [0] rx nonempty [1] tx not full [2] rx full [3] tx empty [4] rx underflow
//             [5] tx overflow [7:6]=0.  W: ignored.
//   1 DATA    R: RX head, pop at fall; RX empty -> 0x00, no pop, set underflow.
//             W: push to TX; TX full -> byte dropped, set overflow.
//   2 IRQ_EN  R/W: [0] rx nonempty [1] tx empty [2] error; [7:3] read 0.
//   3 RX_CNT  R: RX occupancy, saturates at 255. W: any value clears underflow and overflow.
//  irq_n = ~|(IRQ_EN[2:0] & {underflow|overflow, tx empty, rx nonempty}); registered, 1 clk latency.
//  FIFO: registered occupancy; simultaneous push+pop on one FIFO keeps count, both succeed,
//   including push into full when pop is in same cycle. Push to empty visible on head next clk.
//  Pointers wrap modulo FIFO_DEPTH. Error flags are sticky until RX_CNT write or reset.
//  Bus read latency: data_out valid 1 clk after synced rise, <= (SYNC_STAGES+2)*6 ns after phi2 rise.
// STRUCTURE
//  Package per_bus_pkg: register address localparams (REG_STATUS..REG_RX_CNT), STATUS/IRQ_EN
//   bit indices, FSM state enum typedef.
//  Sub-module byte_fifo (DEPTH param; push/pop/full/empty/count), instantiated for TX and RX.
//  Synchronizers, edge detect, FSM, register decode and IRQ logic live in this module.
// TESTING
//  Reset mid-READ (data_oe=1) -> data_oe=0 next clk, irq_n=1, STATUS reads 0x0A after reset.
//  Bus writes 0x11,0x22,0x33 to DATA -> tx_data 0x11,0x22,0x33 in order; STATUS[3] returns to 1.
//  Local push 0xA5; IRQ_EN=0x01 -> irq_n low; bus read DATA -> 0xA5; irq_n high after fall.
//  Read DATA with RX empty -> 0x00, STATUS=0x1A; write RX_CNT -> STATUS=0x0A.
//  17 writes with DEPTH 16, no pops -> 17th dropped, STATUS[5]=1, pops yield first 16 bytes.
//  RX full, local push + bus pop same clk -> RX_CNT stays 16, order preserved, no error.

Source files
------------

// File: rtl/per_bus_pkg.sv
// Shared definitions for the peripheral-bus mailbox: register map,
// STATUS / IRQ_EN bit positions, bus FSM states and a small count helper.
package per_bus_pkg;

   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_DATA   = 2'd1;
   localparam logic [1:0] REG_IRQ_EN = 2'd2;
   localparam logic [1:0] REG_RX_CNT = 2'd3;

   localparam int ST_RX_NONEMPTY  = 0;
   localparam int ST_TX_NOT_FULL  = 1;
   localparam int ST_RX_FULL      = 2;
   localparam int ST_TX_EMPTY     = 3;
   localparam int ST_RX_UNDERFLOW = 4;
   localparam int ST_TX_OVERFLOW  = 5;

   localparam int IE_RX_NONEMPTY = 0;
   localparam int IE_TX_EMPTY    = 1;
   localparam int IE_ERROR       = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2
   } bus_state_e;

   // Occupancy as seen on the 8-bit RX_CNT register (a 256-deep FIFO holds 256).
   function automatic logic [7:0] sat_cnt8(input logic [8:0] cnt);
      return (cnt > 9'd255) ? 8'hFF : cnt[7:0];
   endfunction

endpackage

// File: rtl/per_bus_mailbox_if.sv
// Phi2-timed peripheral bus as seen between the bus controller (master)
// and a responder such as the mailbox (slave).
interface per_bus_mailbox_if;
   logic       phi2;
   logic       cs_n;
   logic       read_write;
   logic [5:0] address;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       data_oe;

   modport master (
      output phi2, cs_n, read_write, address, data_in,
      input  data_out, data_oe
   );

   modport slave (
      input  phi2, cs_n, read_write, address, data_in,
      output data_out, data_oe
   );
endinterface

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with registered occupancy. A push into a full
// FIFO is accepted when a pop happens in the same cycle.
module byte_fifo #(
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_push,
   input  logic [7:0]    i_din,
   input  logic          i_pop,
   output logic [7:0]    o_dout,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_count
);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd_ptr];
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);

   // Storage write; contents need no reset because occupancy gates every read.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks push/pop.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/per_bus_mailbox.sv
// Mailbox responder on the phi2 peripheral bus: synchronises the bus strobes,
// runs the read/write cycle FSM, decodes the 4-register window and drives the
// level interrupt. TX carries host->local bytes, RX local->host bytes.
module per_bus_mailbox
   import per_bus_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int WR_SAMPLE   = 20
) (
   input  logic               i_clk,
   input  logic               i_reset,
   per_bus_mailbox_if.slave   io_bus,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   input  logic [7:0]         i_rx_data,
   input  logic               i_rx_valid,
   output logic               o_rx_ready,
   output logic               o_irq_n
);

   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   localparam int WCW = $clog2(WR_SAMPLE + 1) + 1;

   logic [SYNC_STAGES-1:0] r_phi2_sync, r_cs_n_sync, r_rw_sync;
   logic        r_phi2_last;
   logic        w_phi2_s, w_cs_n_s, w_rw_s, w_rise, w_fall;

   bus_state_e  r_state;
   logic [1:0]  r_addr;
   logic [7:0]  r_data_out;
   logic        r_data_oe;
   logic        r_rd_empty;
   logic [WCW-1:0] r_wcnt;
   logic        r_wcap;
   logic [7:0]  r_wdata;

   logic [2:0]  r_irq_en;
   logic        r_underflow, r_overflow, r_irq_n;

   logic [7:0]  w_rx_head, w_rd_value, w_status, w_wr_byte;
   logic        w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
   logic [CW-1:0] w_rx_count, w_tx_count_unused;
   logic        w_commit_rd, w_commit_wr, w_rx_pop, w_rx_push, w_tx_pop, w_tx_push;
   logic        w_tx_push_req, w_set_uf, w_set_of;
   logic [2:0]  w_irq_src;
   logic        w_unused;

   // Upper address bits only alias the window.
   assign w_unused = ^io_bus.address[5:2];

   // Bring phi2 / cs_n / read_write into the clk domain; reset to the idle-high
   // level so a reset during a high phase cannot fake a rising edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_phi2_sync <= '1;
         r_cs_n_sync <= '1;
         r_rw_sync   <= '1;
         r_phi2_last <= 1'b1;
      end else begin
         r_phi2_sync <= {r_phi2_sync[SYNC_STAGES-2:0], io_bus.phi2};
         r_cs_n_sync <= {r_cs_n_sync[SYNC_STAGES-2:0], io_bus.cs_n};
         r_rw_sync   <= {r_rw_sync[SYNC_STAGES-2:0], io_bus.read_write};
         r_phi2_last <= r_phi2_sync[SYNC_STAGES-1];
      end
   end

   assign w_phi2_s = r_phi2_sync[SYNC_STAGES-1];
   assign w_cs_n_s = r_cs_n_sync[SYNC_STAGES-1];
   assign w_rw_s   = r_rw_sync[SYNC_STAGES-1];
   assign w_rise   = w_phi2_s & ~r_phi2_last;
   assign w_fall   = ~w_phi2_s & r_phi2_last;

   // Bus cycle FSM: latch the access at the rise, present read data or sample
   // write data, and finish the cycle at the fall.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_addr     <= 2'd0;
         r_data_out <= 8'h00;
         r_data_oe  <= 1'b0;
         r_rd_empty <= 1'b0;
         r_wcnt     <= '0;
         r_wcap     <= 1'b0;
         r_wdata    <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_data_oe <= 1'b0;
               if (w_rise && !w_cs_n_s) begin
                  r_addr  <= io_bus.address[1:0];
                  r_wcnt  <= WCW'(1);
                  r_wcap  <= 1'b0;
                  r_state <= w_rw_s ? S_READ : S_WRITE;
               end
            end
            S_READ: begin
               if (w_fall) begin
                  r_data_oe <= 1'b0;
                  r_state   <= S_IDLE;
               end else if (!r_data_oe) begin
                  r_data_out <= w_rd_value;
                  r_data_oe  <= 1'b1;
                  r_rd_empty <= w_rx_empty;
               end
            end
            S_WRITE: begin
               if (w_fall) begin
                  r_state <= S_IDLE;
               end else if (!r_wcap) begin
                  if (r_wcnt == WCW'(WR_SAMPLE)) begin
                     r_wdata <= io_bus.data_in;
                     r_wcap  <= 1'b1;
                  end
                  r_wcnt <= r_wcnt + WCW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_bus.data_out = r_data_out;
   assign io_bus.data_oe  = r_data_oe;

   // Side effects commit only at the fall of a cycle that actually presented data.
   assign w_commit_rd   = (r_state == S_READ) & w_fall & r_data_oe & (r_addr == REG_DATA);
   assign w_commit_wr   = (r_state == S_WRITE) & w_fall;
   assign w_wr_byte     = r_wcap ? r_wdata : io_bus.data_in;
   assign w_rx_pop      = w_commit_rd & ~r_rd_empty;
   assign w_set_uf      = w_commit_rd & r_rd_empty;
   assign w_tx_pop      = ~w_tx_empty & i_tx_ready;
   assign w_tx_push_req = w_commit_wr & (r_addr == REG_DATA);
   assign w_tx_push     = w_tx_push_req & (~w_tx_full | w_tx_pop);
   assign w_set_of      = w_tx_push_req & w_tx_full & ~w_tx_pop;
   assign o_rx_ready    = ~w_rx_full | w_rx_pop;
   assign w_rx_push     = i_rx_valid & o_rx_ready;
   assign o_tx_valid    = ~w_tx_empty;

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_push(w_tx_push), .i_din(w_wr_byte), .i_pop(w_tx_pop),
      .o_dout(o_tx_data), .o_full(w_tx_full), .o_empty(w_tx_empty),
      .o_count(w_tx_count_unused)
   );

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_push(w_rx_push), .i_din(i_rx_data), .i_pop(w_rx_pop),
      .o_dout(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty),
      .o_count(w_rx_count)
   );

   // STATUS image and read-data mux for the register window.
   always_comb begin
      w_status = 8'h00;
      w_status[ST_RX_NONEMPTY]  = ~w_rx_empty;
      w_status[ST_TX_NOT_FULL]  = ~w_tx_full;
      w_status[ST_RX_FULL]      = w_rx_full;
      w_status[ST_TX_EMPTY]     = w_tx_empty;
      w_status[ST_RX_UNDERFLOW] = r_underflow;
      w_status[ST_TX_OVERFLOW]  = r_overflow;
      case (r_addr)
         REG_STATUS: w_rd_value = w_status;
         REG_DATA:   w_rd_value = w_rx_empty ? 8'h00 : w_rx_head;
         REG_IRQ_EN: w_rd_value = {5'b00000, r_irq_en};
         REG_RX_CNT: w_rd_value = sat_cnt8(9'(w_rx_count));
         default:    w_rd_value = 8'h00;
      endcase
   end

   // Interrupt sources in IRQ_EN bit order.
   always_comb begin
      w_irq_src = 3'b000;
      w_irq_src[IE_RX_NONEMPTY] = ~w_rx_empty;
      w_irq_src[IE_TX_EMPTY]    = w_tx_empty;
      w_irq_src[IE_ERROR]       = r_underflow | r_overflow;
   end

   // Control registers, sticky error flags and the registered interrupt line.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_irq_en    <= 3'b000;
         r_underflow <= 1'b0;
         r_overflow  <= 1'b0;
         r_irq_n     <= 1'b1;
      end else begin
         if (w_commit_wr && (r_addr == REG_IRQ_EN)) begin
            r_irq_en <= w_wr_byte[2:0];
         end
         if (w_commit_wr && (r_addr == REG_RX_CNT)) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
         end else begin
            if (w_set_uf) r_underflow <= 1'b1;
            if (w_set_of) r_overflow  <= 1'b1;
         end
         r_irq_n <= ~|(r_irq_en & w_irq_src);
      end
   end

   assign o_irq_n = r_irq_n;

endmodule

// File: tb/tb_per_bus_mailbox.sv
// Directed bench for per_bus_mailbox: a table of register accesses followed
// by hand-written sequences for reset, FIFO ordering, overflow and full-FIFO cases.
module tb_per_bus_mailbox;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       irq_n;

   int n_checks = 0;
   int n_errors = 0;

   always #3 clk = ~clk;

   per_bus_mailbox_if bus_if ();

   per_bus_mailbox #(.FIFO_DEPTH(16), .SYNC_STAGES(2), .WR_SAMPLE(20)) dut (
      .i_clk(clk), .i_reset(reset), .io_bus(bus_if),
      .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
      .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
      .o_irq_n(irq_n)
   );

   typedef struct {
      logic       is_write;
      logic [5:0] addr;
      logic [7:0] data;   // write data, or expected read data
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [5:0] a, input logic [7:0] d, input int hi_cycles);
      @(negedge clk);
      bus_if.address = a; bus_if.read_write = 1'b0; bus_if.cs_n = 1'b0; bus_if.data_in = d;
      repeat (2) @(negedge clk);
      bus_if.phi2 = 1'b1;
      repeat (hi_cycles) @(negedge clk);
      bus_if.phi2 = 1'b0;
      repeat (6) @(negedge clk);
      bus_if.cs_n = 1'b1; bus_if.read_write = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic bus_read(input logic [5:0] a, output logic [7:0] d, output logic oe_mid,
                           output logic oe_after);
      @(negedge clk);
      bus_if.address = a; bus_if.read_write = 1'b1; bus_if.cs_n = 1'b0;
      repeat (2) @(negedge clk);
      bus_if.phi2 = 1'b1;
      repeat (10) @(negedge clk);
      d = bus_if.data_out;
      oe_mid = bus_if.data_oe;
      bus_if.phi2 = 1'b0;
      repeat (6) @(negedge clk);
      oe_after = bus_if.data_oe;
      bus_if.cs_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic read_chk(input string name, input logic [5:0] a, input logic [7:0] exp);
      logic [7:0] d;
      logic       oe_mid, oe_after;
      bus_read(a, d, oe_mid, oe_after);
      chk(name, {8'h00, d}, {8'h00, exp});
      chk({name, "_oe"}, {14'd0, oe_mid, oe_after}, 16'h0002);
   endtask

   task automatic local_push(input logic [7:0] d);
      @(negedge clk);
      rx_data = d; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic local_pop();
      @(negedge clk);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      logic       oe_mid, oe_after, pushed;

      reset = 1'b1;
      bus_if.phi2 = 1'b0; bus_if.cs_n = 1'b1; bus_if.read_write = 1'b1;
      bus_if.address = 6'h00; bus_if.data_in = 8'h00;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      chk("rst_data_oe", {15'd0, bus_if.data_oe}, 16'h0000);
      chk("rst_data_out", {8'h00, bus_if.data_out}, 16'h0000);
      chk("rst_irq_n", {15'd0, irq_n}, 16'h0001);
      chk("rst_tx_valid", {15'd0, tx_valid}, 16'h0000);
      chk("rst_rx_ready", {15'd0, rx_ready}, 16'h0001);

      // Register-window table
      vecs[0]  = '{1'b0, 6'h00, 8'h0A};
      vecs[1]  = '{1'b0, 6'h02, 8'h00};
      vecs[2]  = '{1'b0, 6'h03, 8'h00};
      vecs[3]  = '{1'b1, 6'h02, 8'hFF};
      vecs[4]  = '{1'b0, 6'h02, 8'h07};
      vecs[5]  = '{1'b1, 6'h02, 8'h00};
      vecs[6]  = '{1'b0, 6'h01, 8'h00};
      vecs[7]  = '{1'b0, 6'h00, 8'h1A};
      vecs[8]  = '{1'b1, 6'h03, 8'h55};
      vecs[9]  = '{1'b0, 6'h00, 8'h0A};
      vecs[10] = '{1'b1, 6'h00, 8'hFF};
      vecs[11] = '{1'b0, 6'h00, 8'h0A};
      vecs[12] = '{1'b0, 6'h3E, 8'h00};
      for (int i = 0; i < 13; i++) begin
         if (vecs[i].is_write) begin
            bus_write(vecs[i].addr, vecs[i].data, 30);
         end else begin
            read_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data);
         end
      end

      // Reset in the middle of a read cycle
      bus_write(6'h02, 8'h02, 30);
      repeat (3) @(negedge clk);
      chk("irq_tx_empty", {15'd0, irq_n}, 16'h0000);
      bus_if.address = 6'h00; bus_if.read_write = 1'b1; bus_if.cs_n = 1'b0;
      repeat (2) @(negedge clk);
      bus_if.phi2 = 1'b1;
      repeat (10) @(negedge clk);
      chk("midrd_oe_before", {15'd0, bus_if.data_oe}, 16'h0001);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrd_oe_after", {15'd0, bus_if.data_oe}, 16'h0000);
      chk("midrd_irq_n", {15'd0, irq_n}, 16'h0001);
      repeat (5) @(negedge clk);
      chk("midrd_oe_held", {15'd0, bus_if.data_oe}, 16'h0000);
      bus_if.phi2 = 1'b0;
      repeat (6) @(negedge clk);
      bus_if.cs_n = 1'b1;
      read_chk("post_rst_status", 6'h00, 8'h0A);
      read_chk("post_rst_irq_en", 6'h02, 8'h00);

      // Late data change is after the sample point; short phase captures at the fall
      @(negedge clk);
      bus_if.address = 6'h02; bus_if.read_write = 1'b0; bus_if.cs_n = 1'b0;
      bus_if.data_in = 8'h03;
      repeat (2) @(negedge clk);
      bus_if.phi2 = 1'b1;
      repeat (30) @(negedge clk);
      bus_if.data_in = 8'h04;
      repeat (6) @(negedge clk);
      bus_if.phi2 = 1'b0;
      repeat (6) @(negedge clk);
      bus_if.cs_n = 1'b1;
      read_chk("wr_sample", 6'h02, 8'h03);
      bus_write(6'h02, 8'h05, 5);
      read_chk("wr_short", 6'h02, 8'h05);
      bus_write(6'h02, 8'h00, 30);

      // TX ordering
      bus_write(6'h01, 8'h11, 30);
      bus_write(6'h01, 8'h22, 30);
      bus_write(6'h01, 8'h33, 30);
      read_chk("tx3_status", 6'h00, 8'h02);
      chk("tx_head0", {7'd0, tx_valid, tx_data}, 16'h0111);
      local_pop();
      chk("tx_head1", {7'd0, tx_valid, tx_data}, 16'h0122);
      local_pop();
      chk("tx_head2", {7'd0, tx_valid, tx_data}, 16'h0133);
      local_pop();
      chk("tx_drained", {15'd0, tx_valid}, 16'h0000);
      read_chk("tx_empty_status", 6'h00, 8'h0A);

      // RX interrupt
      local_push(8'hA5);
      bus_write(6'h02, 8'h01, 30);
      repeat (3) @(negedge clk);
      chk("irq_rx_low", {15'd0, irq_n}, 16'h0000);
      read_chk("rx_a5", 6'h01, 8'hA5);
      chk("irq_rx_high", {15'd0, irq_n}, 16'h0001);
      bus_write(6'h02, 8'h00, 30);

      // TX overflow: 17 writes into a 16-deep FIFO
      for (int i = 0; i < 17; i++) begin
         bus_write(6'h01, 8'h40 + 8'(i), 30);
      end
      read_chk("ovf_status", 6'h00, 8'h20);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("ovf_pop%0d", i), {7'd0, tx_valid, tx_data}, {7'd0, 1'b1, 8'h40 + 8'(i)});
         local_pop();
      end
      chk("ovf_drained", {15'd0, tx_valid}, 16'h0000);
      bus_write(6'h03, 8'h00, 30);
      read_chk("ovf_cleared", 6'h00, 8'h0A);

      // RX full, local push in the same clock as the bus pop
      for (int i = 0; i < 16; i++) begin
         local_push(8'h80 + 8'(i));
      end
      read_chk("rxfull_cnt", 6'h03, 8'h10);
      read_chk("rxfull_status", 6'h00, 8'h0F);
      chk("rxfull_ready", {15'd0, rx_ready}, 16'h0000);
      pushed = 1'b0;
      fork
         bus_read(6'h01, d, oe_mid, oe_after);
         begin
            @(negedge clk);
            rx_data = 8'h90; rx_valid = 1'b1;
            for (int k = 0; k < 200 && !pushed; k++) begin
               @(negedge clk);
               if (rx_ready) begin
                  @(negedge clk);
                  pushed = 1'b1;
               end
            end
            rx_valid = 1'b0;
         end
      join
      chk("simul_read", {8'h00, d}, 16'h0080);
      chk("simul_pushed", {15'd0, pushed}, 16'h0001);
      read_chk("simul_cnt", 6'h03, 8'h10);
      read_chk("simul_status", 6'h00, 8'h0F);
      for (int i = 1; i < 16; i++) begin
         read_chk($sformatf("simul_pop%0d", i), 6'h01, 8'h80 + 8'(i));
      end
      read_chk("simul_last", 6'h01, 8'h90);
      read_chk("simul_final_status", 6'h00, 8'h0A);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
